// File: rtl/pe_inv_reorder_buf.sv
// pe_inv_reorder_buf
// Undoes the butterfly input-lane reorder of the rec_tq 1-D transform core.
// It also buffers rows in a 2-entry registered FIFO and tags the last row of
// each transform block.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   i_dt_vld      input row valid
//   o_dt_rdy      block can accept a row (registered from the FIFO count)
//   i_transize    0:4x4 1:8x8 2:16x16 3:32x32
//   i_dt          permuted row, lane n at [DW*n +: DW]
//   o_dt_vld      output row valid
//   i_dt_rdy      downstream ready
//   o_dt          natural-order row, same lane packing
//   o_transize    block size of the row on o_dt
//   o_last        o_dt row is the final row of its block
//   o_size_err    sticky flag: i_transize changed inside a block
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1
// on that side (input: i_dt_vld && o_dt_rdy, output: o_dt_vld && i_dt_rdy).
// Valid never depends on ready. o_dt_rdy comes from a register, so there is
// no combinational path from i_dt_rdy.
module pe_inv_reorder_buf #(
    parameter int DW    = 28,
    parameter int LANES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_dt_vld,
    output logic                  o_dt_rdy,
    input  logic [1:0]            i_transize,
    input  logic [LANES*DW-1:0]   i_dt,
    output logic                  o_dt_vld,
    input  logic                  i_dt_rdy,
    output logic [LANES*DW-1:0]   o_dt,
    output logic [1:0]            o_transize,
    output logic                  o_last,
    output logic                  o_size_err
);

    localparam int RW = LANES * DW;

    logic [1:0]    count, count_nxt;
    logic          rdy_q;
    logic [RW-1:0] head_dt, tail_dt;
    logic [1:0]    head_sz, tail_sz;
    logic          head_last, tail_last;
    logic [4:0]    rc;
    logic [1:0]    blk_sz;
    logic          size_err;

    logic          push, pop;
    logic [1:0]    cur_sz;
    logic          row_last;
    logic [RW-1:0] perm_dt;

    // 8-point helper: even 2j -> j, odd 2j+1 -> 4+j.
    function automatic logic [2:0] map8(input logic [2:0] k);
        return {k[0], k[2:1]};
    endfunction

    // 16-point helper: even 2j -> map8(j), odd 2j+1 -> 8+j.
    function automatic logic [3:0] map16(input logic [3:0] k);
        return k[0] ? {1'b1, k[3:1]} : {1'b0, map8(k[3:1])};
    endfunction

    // Forward map p(k): the forward reorder fed output lane k from lane p(k).
    function automatic logic [4:0] map_p(input logic [1:0] sz, input logic [4:0] k);
        logic [4:0] p;
        case (sz)
            2'd0:    p = k;
            2'd1:    p = {k[4:3], map8(k[2:0])};
            2'd2:    p = {k[4], map16(k[3:0])};
            default: p = k[0] ? {1'b1, k[4:1]} : {1'b0, map16(k[4:1])};
        endcase
        return p;
    endfunction

    assign push = i_dt_vld && rdy_q;
    assign pop  = o_dt_vld && i_dt_rdy;

    // The first row of a block uses the size being latched this cycle.
    assign cur_sz = (rc == 5'd0) ? i_transize : blk_sz;

    always_comb begin
        row_last = 1'b0;
        case (cur_sz)
            2'd0:    row_last = (rc == 5'd3);
            2'd1:    row_last = (rc == 5'd7);
            2'd2:    row_last = (rc == 5'd15);
            default: row_last = (rc == 5'd31);
        endcase
    end

    // Scatter: out[p(k)] = in[k]. p is a bijection, so every lane is written.
    always_comb begin
        perm_dt = '0;
        for (int k = 0; k < LANES; k++) begin
            perm_dt[DW*int'(map_p(cur_sz, k[4:0])) +: DW] = i_dt[DW*k +: DW];
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            rdy_q     <= 1'b0;
            head_dt   <= '0;
            head_sz   <= 2'd0;
            head_last <= 1'b0;
            tail_dt   <= '0;
            tail_sz   <= 2'd0;
            tail_last <= 1'b0;
            rc        <= 5'd0;
            blk_sz    <= 2'd0;
            size_err  <= 1'b0;
        end else begin
            count <= count_nxt;
            rdy_q <= (count_nxt < 2'd2);

            if (push) begin
                rc <= row_last ? 5'd0 : rc + 5'd1;
                if (rc == 5'd0) begin
                    blk_sz <= i_transize;
                end
                if (rc != 5'd0 && i_transize != blk_sz) begin
                    size_err <= 1'b1;
                end
            end

            // push && pop only happens at count 1 (push needs count<2,
            // pop needs count>0), so the new row goes straight to the head.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_dt   <= perm_dt;
                        head_sz   <= cur_sz;
                        head_last <= row_last;
                    end else begin
                        tail_dt   <= perm_dt;
                        tail_sz   <= cur_sz;
                        tail_last <= row_last;
                    end
                end
                2'b01: begin
                    // Popping the last entry leaves the head untouched so
                    // o_dt keeps its previous value.
                    if (count == 2'd2) begin
                        head_dt   <= tail_dt;
                        head_sz   <= tail_sz;
                        head_last <= tail_last;
                    end
                end
                2'b11: begin
                    head_dt   <= perm_dt;
                    head_sz   <= cur_sz;
                    head_last <= row_last;
                end
                default: ;
            endcase
        end
    end

    assign o_dt_rdy   = rdy_q;
    assign o_dt_vld   = (count != 2'd0);
    assign o_dt       = head_dt;
    assign o_transize = head_sz;
    assign o_last     = head_last;
    assign o_size_err = size_err;

endmodule

// File: tb/tb_pe_inv_reorder_buf.sv
module tb_pe_inv_reorder_buf;

    localparam int DW    = 28;
    localparam int LANES = 32;
    localparam int RW    = LANES * DW;
    localparam int EW    = RW + 3;

    logic            clk;
    logic            rst;
    logic            i_dt_vld;
    logic            o_dt_rdy;
    logic [1:0]      i_transize;
    logic [RW-1:0]   i_dt;
    logic            o_dt_vld;
    logic            i_dt_rdy;
    logic [RW-1:0]   o_dt;
    logic [1:0]      o_transize;
    logic            o_last;
    logic            o_size_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] drv_exp;

    pe_inv_reorder_buf #(.DW(DW), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_dt_vld   (i_dt_vld),
        .o_dt_rdy   (o_dt_rdy),
        .i_transize (i_transize),
        .i_dt       (i_dt),
        .o_dt_vld   (o_dt_vld),
        .i_dt_rdy   (i_dt_rdy),
        .o_dt       (o_dt),
        .o_transize (o_transize),
        .o_last     (o_last),
        .o_size_err (o_size_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int r8(input int k);
        return (k % 2 == 0) ? k / 2 : 4 + k / 2;
    endfunction

    function automatic int q16(input int k);
        return (k % 2 == 0) ? r8(k / 2) : 8 + k / 2;
    endfunction

    function automatic int pmap(input int sz, input int k);
        case (sz)
            0:       return k;
            1:       return (k / 8) * 8 + r8(k % 8);
            2:       return (k / 16) * 16 + q16(k % 16);
            default: return (k % 2 == 0) ? q16(k / 2) : 16 + k / 2;
        endcase
    endfunction

    // Forward reorder (gather): out lane k takes natural lane p(k).
    function automatic logic [RW-1:0] fwd(input logic [RW-1:0] nat, input int sz);
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = nat[pmap(sz, k)*DW +: DW];
        return v;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'($urandom_range(32'hffff_ffff, 0));
        return v;
    endfunction

    function automatic logic [DW-1:0] lane(input logic [RW-1:0] v, input int n);
        return v[n*DW +: DW];
    endfunction

    // ---------------- scoreboard ----------------
    // Sampled at negedge: a beat seen valid/ready here moves on the next posedge.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (o_dt_vld && i_dt_rdy) begin
                chk("sb_nonempty", RW'(exp_q.size() != 0), RW'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_dt", o_dt, e[RW-1:0]);
                    chk("sb_sz", RW'(o_transize), RW'(e[RW+1:RW]));
                    chk("sb_last", RW'(o_last), RW'(e[RW+2]));
                end
            end
            if (i_dt_vld && o_dt_rdy) exp_q.push_back(drv_exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [RW-1:0] dt, input logic [1:0] ts,
                            input logic [RW-1:0] edt, input logic [1:0] ets, input logic elast);
        int   waits;
        logic acc;
        i_dt       = dt;
        i_transize = ts;
        i_dt_vld   = 1'b1;
        drv_exp    = {elast, ets, edt};
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = o_dt_rdy;
            @(posedge clk);
            waits++;
        end
        #1;
        i_dt_vld = 1'b0;
        chk("send_acc", RW'(acc), RW'(1));
    endtask

    // Full or partial block of random natural rows, driven in forward order.
    task automatic send_block(input int sz, input int nrows);
        logic [RW-1:0] nat;
        for (int r = 0; r < nrows; r++) begin
            nat = rand_row();
            send_row(fwd(nat, sz), 2'(sz), nat, 2'(sz), r == ((4 << sz) - 1));
        end
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_vld", RW'(o_dt_vld), RW'(0));
        chk("rst_rdy", RW'(o_dt_rdy), RW'(0));
        chk("rst_dt", o_dt, RW'(0));
        chk("rst_sz", RW'(o_transize), RW'(0));
        chk("rst_last", RW'(o_last), RW'(0));
        chk("rst_err", RW'(o_size_err), RW'(0));
        rst = 1'b0;
        idle(1);
        chk("rst_rdy_after", RW'(o_dt_rdy), RW'(1));
        chk("rst_vld_after", RW'(o_dt_vld), RW'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [RW-1:0] row, expr, nat, hold;
        int t0;

        rst = 1'b1; i_dt_vld = 1'b0; i_dt_rdy = 1'b1; i_transize = 2'd0; i_dt = '0; drv_exp = '0;
        idle(2);
        do_reset();

        // Identity, 4x4
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < LANES; n++) row[n*DW +: DW] = DW'(32'h100 * r + n);
            send_row(row, 2'd0, row, 2'd0, r == 3);
            chk("id_lat_vld", RW'(o_dt_vld), RW'(1));
            chk("id_lat_dt", o_dt, row);
        end
        idle(3);

        // 32x32: first row lane k = k, expected built directly from the even/odd rule
        for (int n = 0; n < LANES; n++) row[n*DW +: DW] = DW'(n);
        for (int j = 0; j < 16; j++) begin
            expr[q16(j)*DW +: DW]     = DW'(2 * j);
            expr[(16 + j)*DW +: DW]   = DW'(2 * j + 1);
        end
        i_dt_rdy = 1'b0;
        send_row(row, 2'd3, expr, 2'd3, 1'b0);
        chk("t32_l8", RW'(lane(o_dt, 8)), RW'(2));
        chk("t32_l4", RW'(lane(o_dt, 4)), RW'(4));
        chk("t32_l9", RW'(lane(o_dt, 9)), RW'(6));
        chk("t32_l16", RW'(lane(o_dt, 16)), RW'(1));
        chk("t32_l31", RW'(lane(o_dt, 31)), RW'(31));
        i_dt_rdy = 1'b1;
        for (int r = 1; r < 32; r++) begin
            nat = rand_row();
            send_row(fwd(nat, 3), 2'd3, nat, 2'd3, r == 31);
        end
        idle(2);

        // Round trip for every size
        for (int sz = 0; sz < 4; sz++) send_block(sz, 4 << sz);
        idle(3);

        // Backpressure: 8x8, downstream stalled for a few cycles
        fork
            send_block(1, 8);
            begin
                idle(1);
                i_dt_rdy = 1'b0;
                idle(1);
                hold = o_dt;
                for (int c = 0; c < 4; c++) begin
                    idle(1);
                    chk("bp_stable", o_dt, hold);
                    chk("bp_vld", RW'(o_dt_vld), RW'(1));
                end
                chk("bp_rdy_low", RW'(o_dt_rdy), RW'(0));
                i_dt_rdy = 1'b1;
            end
        join
        idle(4);
        chk("bp_drained", RW'(exp_q.size()), RW'(0));

        // Streaming at count 1: one row per cycle
        t0 = cyc;
        for (int r = 0; r < 8; r++) begin
            nat = rand_row();
            send_row(nat, 2'd0, nat, 2'd0, (r % 4) == 3);
            chk("tp_vld", RW'(o_dt_vld), RW'(1));
            chk("tp_rdy", RW'(o_dt_rdy), RW'(1));
        end
        chk("tp_cycles", RW'(cyc - t0), RW'(8));
        idle(3);

        // Size error: 16x16 block, row 5 presented as 8x8
        for (int r = 0; r < 16; r++) begin
            nat = rand_row();
            send_row(fwd(nat, 2), (r == 5) ? 2'd1 : 2'd2, nat, 2'd2, r == 15);
            if (r == 4) chk("err_pre", RW'(o_size_err), RW'(0));
            if (r == 5) chk("err_set", RW'(o_size_err), RW'(1));
        end
        send_block(0, 4);
        chk("err_keep", RW'(o_size_err), RW'(1));
        idle(3);

        // Mid-block reset with two rows buffered
        send_block(2, 1);
        idle(1);
        i_dt_rdy = 1'b0;
        for (int r = 1; r < 3; r++) begin
            nat = rand_row();
            send_row(fwd(nat, 2), 2'd2, nat, 2'd2, 1'b0);
        end
        chk("mr_full_rdy", RW'(o_dt_rdy), RW'(0));
        do_reset();
        i_dt_rdy = 1'b1;
        send_block(0, 4);
        idle(3);
        chk("mr_err_clear", RW'(o_size_err), RW'(0));
        chk("end_drained", RW'(exp_q.size()), RW'(0));

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_inv_reorder_buf.md
Name: pe_inv_reorder_buf

Overview:
- Inverse of the butterfly input-lane reorder in the rec_tq DCT/IDCT datapath.
- Takes one 32-lane row per beat, in butterfly (permuted) order, and returns it to natural coefficient order.
- Buffers rows in a 2-entry registered FIFO with valid/ready on both sides, and tags the last row of each transform block.
- Sits between the 1-D transform core and the transpose/quant stage.

Parameters:
- DW, 28, lane width in bits.
- LANES, 32, lanes per row; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_dt_vld  in  1  input row valid
- o_dt_rdy  out  1  block can accept a row
- i_transize  in  2  0:4x4, 1:8x8, 2:16x16, 3:32x32
- i_dt  in  LANES*DW  permuted row; lane n at [DW*n+DW-1 : DW*n]
- o_dt_vld  out  1  output row valid
- i_dt_rdy  in  1  downstream ready
- o_dt  out  LANES*DW  natural-order row, same lane packing
- o_transize  out  2  block size of the row on o_dt
- o_last  out  1  o_dt row is the final row of its block
- o_size_err  out  1  sticky: i_transize changed mid-block

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high. All state updates on the rising edge of clk.
- Forward map p(k): the forward reorder drives output lane k from input lane p(k). This block computes out[p(k)] = in[k] for all k.
- Helper r (8-point): even k=2j -> j; odd k=2j+1 -> 4+j.
- Helper q (16-point): even k=2j -> r(j); odd k=2j+1 -> 8+j.
- transize 0: p(k)=k (identity).
- transize 1: applied per 8-lane group g in {0,8,16,24}: p(g+k)=g+r(k).
- transize 2: applied per 16-lane half h in {0,16}: p(h+k)=h+q(k).
- transize 3: even k=2j -> q(j); odd k=2j+1 -> 16+j.
- Transfer rules:
  - Accept when i_dt_vld && o_dt_rdy.
  - Emit when o_dt_vld && i_dt_rdy.
  - Data is never dropped or duplicated.
- FIFO:
  - 2 entries; stores un-permuted data, transize and last flag.
  - Permutation is applied before the write.
  - o_dt, o_transize and o_last come straight from the head-entry registers.
- Latency: a row accepted in cycle N appears on o_dt in cycle N+1 if the FIFO was empty.
- o_dt_rdy = (count < 2), registered from count, with no combinational path from i_dt_rdy.
- Simultaneous push and pop at count 1: count stays 1; the head becomes the new row, written and read-through the same edge.
- At count 2: o_dt_rdy=0. A pop in that cycle gives count 1 and o_dt_rdy=1 next cycle.
- Backpressure: while o_dt_vld && !i_dt_rdy, o_dt, o_transize and o_last hold stable.
- Block tracking:
  - Row counter rc (5 bits) counts accepted rows.
  - On accept with rc==0, i_transize is latched as blk_sz.
  - Rows per block R = 4<<blk_sz (4, 8, 16, 32).
  - The stored last flag = (rc == R-1). Then rc wraps to 0; otherwise rc increments.
  - The permutation and the stored transize always use blk_sz; for the first row of a block that is the value being latched.
- Size mismatch: on accept with rc!=0 and i_transize != blk_sz, set o_size_err=1. The row is still processed with blk_sz. o_size_err clears only on rst.
- Reset values, applied on any rst cycle including mid-block (FIFO flushed, partial block discarded):
  - o_dt_vld=0, o_dt_rdy=0 during the rst cycle, then 1 the cycle after.
  - o_dt=0, o_transize=0, o_last=0, o_size_err=0.
  - count=0, rc=0, blk_sz=0.
- No X: o_dt holds its last value when o_dt_vld=0.

Test Plan:
- Identity: transize 0, 4 rows with lane n = 28'h100*row+n -> o_dt equals i_dt, 1-cycle latency; o_last=1 only on row 3; o_transize=0.
- 32x32 inverse: transize 3, i_dt lane k=k.
  - Required: out lane q(j)=2j for j=0..15 (out[8]=2, out[4]=4, out[9]=6), and out lane 16+j=2j+1 (out[16]=1, out[31]=31).
  - Chained with a forward-reorder model, output equals the original row for all 4 sizes, random data.
- Backpressure: transize 1, 8 rows back-to-back, i_dt_rdy low for cycles 2-6.
  - o_dt_rdy drops after 2 rows buffered; o_dt stable while stalled.
  - All 8 rows arrive in order; o_last on the 8th.
- Concurrent push/pop at count 1 with i_dt_rdy=1 and continuous i_dt_vld -> throughput 1 row/cycle, count stays 1, no gaps.
- Size error: transize 2, change i_transize to 1 on row 5 -> o_size_err=1 from next cycle; the row still uses the 16-point map; o_last on row 15; the error persists into the next block.
- Mid-block reset: assert rst after 3 of 16 rows with 2 buffered -> next cycle o_dt_vld=0, count=0, o_size_err=0.
  - A new 4x4 block then yields o_last on its 4th row.
